// File: rtl/ppu_arbiter.sv
// ppu_arbiter
//   Shares a single ppu_top among NREQ requesters. A round-robin arbiter picks
//   one requester per cycle and issues its operands to the PPU through
//   registered outputs. An in-order tag FIFO records which requester issued
//   each operation, so every PPU result can be routed back to its owner.
//
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_in1/in2/op    packed per-requester operands, requester i at [i*W +: W]
//   ppu_valid_in, ppu_in1, ppu_in2, ppu_op   registered issue to ppu_top
//   ppu_out, ppu_valid_o                     result from ppu_top
//   rsp_valid         one-hot result strobe; rsp_data is the shared result bus
//   inflight          tag FIFO occupancy
//   err_orphan        sticky flag, set by a result that arrives with no tag
module ppu_arbiter #(
  parameter int WORD         = 32,
  parameter int OP_SIZE      = 3,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 8,
  localparam int IDW         = $clog2(NREQ),
  localparam int AW          = $clog2(MAX_INFLIGHT),
  localparam int CW          = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WORD-1:0]    req_in1,
  input  logic [NREQ*WORD-1:0]    req_in2,
  input  logic [NREQ*OP_SIZE-1:0] req_op,
  output logic                    ppu_valid_in,
  output logic [WORD-1:0]         ppu_in1,
  output logic [WORD-1:0]         ppu_in2,
  output logic [OP_SIZE-1:0]      ppu_op,
  input  logic [WORD-1:0]         ppu_out,
  input  logic                    ppu_valid_o,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WORD-1:0]         rsp_data,
  output logic [CW-1:0]           inflight,
  output logic                    err_orphan
);

  logic [WORD-1:0]    in1_arr [NREQ];
  logic [WORD-1:0]    in2_arr [NREQ];
  logic [OP_SIZE-1:0] op_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign in1_arr[g] = req_in1[g*WORD +: WORD];
    assign in2_arr[g] = req_in2[g*WORD +: WORD];
    assign op_arr[g]  = req_op[g*OP_SIZE +: OP_SIZE];
  end

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic           cand_found;
  logic [IDW-1:0] idx_id;
  int             idx;

  logic [IDW-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic full;
  logic push;
  logic pop;

  // Search from ptr+1 upward; iterating from the farthest offset down lets the
  // nearest valid requester overwrite earlier hits and win.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    idx        = 0;
    idx_id     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx    = (int'(ptr) + k) % NREQ;
      idx_id = IDW'(idx);
      if (req_valid[idx_id]) begin
        cand_found = 1'b1;
        cand       = idx_id;
      end
    end
  end

  // Grant looks only at the registered count, never at a same-cycle pop, so a
  // full FIFO blocks issue even while a result is being returned.
  assign full      = (count == CW'(MAX_INFLIGHT));
  assign req_ready = (cand_found && !full) ? (NREQ'(1) << cand) : '0;
  assign push      = cand_found && !full;
  assign pop       = ppu_valid_o && (count != '0);
  assign inflight  = count;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= IDW'(NREQ - 1);
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ppu_valid_in <= 1'b0;
      ppu_in1      <= '0;
      ppu_in2      <= '0;
      ppu_op       <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      err_orphan   <= 1'b0;
    end else begin
      ppu_valid_in <= push;
      if (push) begin
        ptr     <= cand;
        wr_ptr  <= wr_ptr + AW'(1);
        ppu_in1 <= in1_arr[cand];
        ppu_in2 <= in2_arr[cand];
        ppu_op  <= op_arr[cand];
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rsp_valid <= NREQ'(1) << tag_mem[rd_ptr];
        rsp_data  <= ppu_out;
      end else begin
        rsp_valid <= '0;
      end

      if (ppu_valid_o && (count == '0)) err_orphan <= 1'b1;

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_arbiter.sv
// tb_ppu_arbiter
//   Directed bench for ppu_arbiter with NREQ=4, MAX_INFLIGHT=8. The PPU is
//   played by the bench itself: results are injected on ppu_valid_o/ppu_out
//   at chosen cycles, and expected routing is hand-computed per vector.
module tb_ppu_arbiter;

  localparam int WORD = 32;
  localparam int OPS  = 3;
  localparam int NREQ = 4;
  localparam int MAXI = 8;
  localparam int CW   = $clog2(MAXI) + 1;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*WORD-1:0] req_in1;
  logic [NREQ*WORD-1:0] req_in2;
  logic [NREQ*OPS-1:0]  req_op;
  logic                 ppu_valid_in;
  logic [WORD-1:0]      ppu_in1;
  logic [WORD-1:0]      ppu_in2;
  logic [OPS-1:0]       ppu_op;
  logic [WORD-1:0]      ppu_out;
  logic                 ppu_valid_o;
  logic [NREQ-1:0]      rsp_valid;
  logic [WORD-1:0]      rsp_data;
  logic [CW-1:0]        inflight;
  logic                 err_orphan;

  int compared;
  int mismatched;

  ppu_arbiter #(.WORD(WORD), .OP_SIZE(OPS), .NREQ(NREQ), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .ppu_valid_in(ppu_valid_in), .ppu_in1(ppu_in1), .ppu_in2(ppu_in2), .ppu_op(ppu_op),
    .ppu_out(ppu_out), .ppu_valid_o(ppu_valid_o),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  // Drives requester valids and the model PPU result port, then lets
  // combinational outputs settle.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic pv, input logic [WORD-1:0] pdata);
    req_valid   = valid;
    ppu_valid_o = pv;
    ppu_out     = pdata;
    #1;
  endtask

  task automatic setOperands(input int i, input logic [WORD-1:0] a, input logic [WORD-1:0] b, input logic [OPS-1:0] op);
    req_in1[i*WORD +: WORD] = a;
    req_in2[i*WORD +: WORD] = b;
    req_op[i*OPS +: OPS]    = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    applyStimulus('0, 1'b0, '0);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step();
  endtask

  logic [NREQ-1:0] exp_onehot;

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    req_valid   = '0;
    req_in1     = '0;
    req_in2     = '0;
    req_op      = '0;
    ppu_valid_o = 1'b0;
    ppu_out     = '0;

    // Reset state
    #12;
    checkOutput("rst_valid_in", 64'(ppu_valid_in), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_inflight", 64'(inflight), 64'd0);
    checkOutput("rst_orphan", 64'(err_orphan), 64'd0);
    checkOutput("rst_in1", 64'(ppu_in1), 64'd0);
    rst = 1'b1;
    step();

    // Single requester, no contention
    setOperands(0, 32'h4000_0000, 32'h4000_0000, 3'd0);
    applyStimulus(4'b0001, 1'b0, '0);
    checkOutput("single_ready", 64'(req_ready), 64'h1);
    step();
    checkOutput("single_issue", 64'(ppu_valid_in), 64'd1);
    checkOutput("single_in1", 64'(ppu_in1), 64'h4000_0000);
    checkOutput("single_in2", 64'(ppu_in2), 64'h4000_0000);
    checkOutput("single_op", 64'(ppu_op), 64'd0);
    checkOutput("single_inflight", 64'(inflight), 64'd1);
    applyStimulus(4'b0000, 1'b1, 32'h4800_0000);
    step();
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("single_rsp_data", 64'(rsp_data), 64'h4800_0000);
    checkOutput("single_inflight0", 64'(inflight), 64'd0);
    checkOutput("single_idle", 64'(ppu_valid_in), 64'd0);
    applyStimulus(4'b0000, 1'b0, '0);

    // Round-robin from a fresh reset: grants 0,1,2,3,0,1,2,3
    pulseReset();
    for (int i = 0; i < NREQ; i++)
      setOperands(i, 32'h100 + i, 32'h200 + i, 3'(i));
    applyStimulus(4'b1111, 1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      exp_onehot = 4'b0001 << (c % 4);
      checkOutput($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(exp_onehot));
      step();
      checkOutput($sformatf("rr_issue%0d", c), 64'(ppu_valid_in), 64'd1);
      checkOutput($sformatf("rr_in1_%0d", c), 64'(ppu_in1), 64'h100 + 64'(c % 4));
    end
    checkOutput("rr_full", 64'(inflight), 64'd8);
    checkOutput("rr_blocked", 64'(req_ready), 64'd0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 1'b1, 32'hA0 + c);
      step();
      exp_onehot = 4'b0001 << (c % 4);
      checkOutput($sformatf("rr_rsp%0d", c), 64'(rsp_valid), 64'(exp_onehot));
      checkOutput($sformatf("rr_data%0d", c), 64'(rsp_data), 64'hA0 + 64'(c));
    end
    applyStimulus(4'b0000, 1'b0, '0);
    checkOutput("rr_drained", 64'(inflight), 64'd0);

    // Full stall with requester 2 streaming and results withheld
    applyStimulus(4'b0100, 1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("stall_ready%0d", c), 64'(req_ready), 64'h4);
      step();
    end
    checkOutput("stall_inflight", 64'(inflight), 64'd8);
    checkOutput("stall_noready", 64'(req_ready), 64'd0);
    step();
    checkOutput("stall_noissue", 64'(ppu_valid_in), 64'd0);
    applyStimulus(4'b0100, 1'b1, 32'h55);
    checkOutput("stall_popcycle_ready", 64'(req_ready), 64'd0);
    step();
    checkOutput("stall_after_pop", 64'(inflight), 64'd7);
    checkOutput("stall_rsp", 64'(rsp_valid), 64'h4);
    checkOutput("stall_noissue2", 64'(ppu_valid_in), 64'd0);
    applyStimulus(4'b0100, 1'b0, '0);
    checkOutput("stall_ready_again", 64'(req_ready), 64'h4);
    step();
    checkOutput("stall_refill", 64'(inflight), 64'd8);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 1'b1, 32'h60 + c);
      step();
    end
    applyStimulus(4'b0000, 1'b0, '0);
    checkOutput("stall_drained", 64'(inflight), 64'd0);
    checkOutput("stall_last_rsp", 64'(rsp_valid), 64'h4);

    // Simultaneous push and pop at occupancy 3. Last grant was 2, so with
    // requesters 0,1 valid the IDs issued are 0,1,0 and the next candidate is 1.
    applyStimulus(4'b0011, 1'b0, '0);
    step();
    step();
    step();
    checkOutput("sim_occ", 64'(inflight), 64'd3);
    applyStimulus(4'b0011, 1'b1, 32'h33);
    checkOutput("sim_ready", 64'(req_ready), 64'h2);
    step();
    checkOutput("sim_inflight", 64'(inflight), 64'd3);
    checkOutput("sim_rsp", 64'(rsp_valid), 64'h1);
    checkOutput("sim_data", 64'(rsp_data), 64'h33);
    checkOutput("sim_issue", 64'(ppu_valid_in), 64'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1, 32'h70 + c);
      step();
      exp_onehot = (c == 1) ? 4'b0001 : 4'b0010;
      checkOutput($sformatf("sim_drain%0d", c), 64'(rsp_valid), 64'(exp_onehot));
    end
    applyStimulus(4'b0000, 1'b0, '0);
    checkOutput("sim_empty", 64'(inflight), 64'd0);

    // Orphan result
    applyStimulus(4'b0000, 1'b1, 32'hDEAD_BEEF);
    step();
    checkOutput("orphan_set", 64'(err_orphan), 64'd1);
    checkOutput("orphan_norsp", 64'(rsp_valid), 64'd0);
    checkOutput("orphan_inflight", 64'(inflight), 64'd0);
    checkOutput("orphan_data_hold", 64'(rsp_data), 64'h72);
    applyStimulus(4'b0000, 1'b0, '0);
    step();
    step();
    checkOutput("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset mid-operation with 5 operations in flight
    applyStimulus(4'b1111, 1'b0, '0);
    for (int c = 0; c < 5; c++) step();
    checkOutput("mid_inflight", 64'(inflight), 64'd5);
    checkOutput("mid_issue", 64'(ppu_valid_in), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_issue", 64'(ppu_valid_in), 64'd0);
    checkOutput("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    checkOutput("mid_rst_inflight", 64'(inflight), 64'd0);
    checkOutput("mid_rst_orphan", 64'(err_orphan), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_prio0", 64'(req_ready), 64'h1);
    step();
    checkOutput("mid_issue0", 64'(ppu_in1), 64'h100);
    checkOutput("mid_inflight1", 64'(inflight), 64'd1);
    applyStimulus(4'b0000, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
